// File: rtl/dbi_tx_fsm_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dbi_tx_fsm_if
// Purpose  : Bundles the pixel-stream handshake and the DBI TX PHY beat
//            interface used by dbi_tx_fsm.
// Ports    : (interface signals)
//   pxl_dat_i        pixel data, high byte sent first
//   pxl_vld_i        pixel valid
//   pxl_rdy_o        pixel accepted when pxl_vld_i & pxl_rdy_o
//   dtf_tx_rdy_i     PHY ready
//   dtf_dbi_hrst_o   beat is a hardware-reset request
//   dtf_tx_cmd_typ_o command byte (first beat of a transaction)
//   dtf_tx_cmd_dat_o parameter / data byte
//   dtf_tx_no_dat_o  command carries no parameters
//   dtf_tx_last_o    last data byte of the transaction
//   dtf_tx_vld_o     beat valid
// Modports : master = sequencer side, slave = pixel source / PHY side
// Revision : 1.0 - initial release
// ============================================================================
interface dbi_tx_fsm_if #(
  parameter int DBI_IF_D_W = 8,
  parameter int PXL_W      = 16
);
  logic [PXL_W-1:0]      pxl_dat_i;
  logic                  pxl_vld_i;
  logic                  pxl_rdy_o;
  logic                  dtf_tx_rdy_i;
  logic                  dtf_dbi_hrst_o;
  logic [DBI_IF_D_W-1:0] dtf_tx_cmd_typ_o;
  logic [DBI_IF_D_W-1:0] dtf_tx_cmd_dat_o;
  logic                  dtf_tx_no_dat_o;
  logic                  dtf_tx_last_o;
  logic                  dtf_tx_vld_o;

  modport master (
    input  pxl_dat_i, pxl_vld_i, dtf_tx_rdy_i,
    output pxl_rdy_o, dtf_dbi_hrst_o, dtf_tx_cmd_typ_o, dtf_tx_cmd_dat_o,
           dtf_tx_no_dat_o, dtf_tx_last_o, dtf_tx_vld_o
  );

  modport slave (
    output pxl_dat_i, pxl_vld_i, dtf_tx_rdy_i,
    input  pxl_rdy_o, dtf_dbi_hrst_o, dtf_tx_cmd_typ_o, dtf_tx_cmd_dat_o,
           dtf_tx_no_dat_o, dtf_tx_last_o, dtf_tx_vld_o
  );
endinterface
`default_nettype wire

// File: rtl/dbi_tx_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dbi_tx_fsm
// Purpose  : Command/pixel sequencer in front of the DBI TX PHY. Runs the
//            panel bring-up (HW reset, SLPOUT, COLMOD, DISPON) and then loops
//            per frame over CASET, RASET and RAMWR, streaming RGB565 pixels
//            as byte beats with full valid/ready handshaking.
// Ports    :
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   bus          dbi_tx_fsm_if.master (pixel stream + PHY beat interface)
//   init_done_o  bring-up finished, frame loop running (sticky until reset)
// Revision : 1.0 - initial release
// ============================================================================
module dbi_tx_fsm #(
  parameter int  INTERNAL_CLK      = 125000000,
  parameter int  DBI_IF_D_W        = 8,
  parameter int  PXL_W             = 16,
  parameter int  H_RES             = 320,
  parameter int  V_RES             = 240,
  parameter real T_HRST_WAIT_SEC   = 120e-3,
  parameter real T_SLPOUT_WAIT_SEC = 120e-3
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  dbi_tx_fsm_if.master  bus,
  output logic          init_done_o
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int C_HRST_RAW = $rtoi(T_HRST_WAIT_SEC * INTERNAL_CLK);
  localparam int C_SLP_RAW  = $rtoi(T_SLPOUT_WAIT_SEC * INTERNAL_CLK);
  localparam int C_HRST_CYC = (C_HRST_RAW < 1) ? 1 : C_HRST_RAW;
  localparam int C_SLP_CYC  = (C_SLP_RAW < 1) ? 1 : C_SLP_RAW;
  localparam int C_TMR_MAX  = (C_HRST_CYC > C_SLP_CYC) ? C_HRST_CYC : C_SLP_CYC;
  localparam int C_TMR_W    = (C_TMR_MAX > 1) ? $clog2(C_TMR_MAX) : 1;

  localparam int C_NPIX     = H_RES * V_RES;
  localparam int C_CNT_W    = (C_NPIX > 1) ? $clog2(C_NPIX) : 1;

  localparam logic [C_TMR_W-1:0] C_HRST_LOAD = C_TMR_W'(C_HRST_CYC - 1);
  localparam logic [C_TMR_W-1:0] C_SLP_LOAD  = C_TMR_W'(C_SLP_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_PIX_LAST  = C_CNT_W'(C_NPIX - 1);
  localparam logic [15:0]        C_COL_END   = 16'(H_RES - 1);
  localparam logic [15:0]        C_ROW_END   = 16'(V_RES - 1);

  localparam logic [DBI_IF_D_W-1:0] C_CMD_SLPOUT = DBI_IF_D_W'(8'h11);
  localparam logic [DBI_IF_D_W-1:0] C_CMD_COLMOD = DBI_IF_D_W'(8'h3A);
  localparam logic [DBI_IF_D_W-1:0] C_DAT_COLMOD = DBI_IF_D_W'(8'h55);
  localparam logic [DBI_IF_D_W-1:0] C_CMD_DISPON = DBI_IF_D_W'(8'h29);
  localparam logic [DBI_IF_D_W-1:0] C_CMD_CASET  = DBI_IF_D_W'(8'h2A);
  localparam logic [DBI_IF_D_W-1:0] C_CMD_RASET  = DBI_IF_D_W'(8'h2B);
  localparam logic [DBI_IF_D_W-1:0] C_CMD_RAMWR  = DBI_IF_D_W'(8'h2C);

  typedef enum logic [3:0] {
    RST_ST    = 4'd0,
    HW_WAIT   = 4'd1,
    SLPOUT_ST = 4'd2,
    SLP_WAIT  = 4'd3,
    COLMOD_ST = 4'd4,
    DISPON_ST = 4'd5,
    CASET_ST  = 4'd6,
    RASET_ST  = 4'd7,
    RAMWR_ST  = 4'd8
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [C_TMR_W-1:0] tmr_q,       tmr_d;
  logic [C_CNT_W-1:0] cnt_q,       cnt_d;
  logic [1:0]         idx_q,       idx_d;
  logic [PXL_W-1:0]   buf_q,       buf_d;
  logic               buf_vld_q,   buf_vld_d;
  logic               sel_lo_q,    sel_lo_d;
  logic               init_done_q, init_done_d;
  // Holds the hrst beat off until the first clock after reset release, so
  // every output really is 0 while rst_n is low.
  logic               arm_q,       arm_d;

  // Combinational beat fields
  logic                  w_hrst;
  logic [DBI_IF_D_W-1:0] w_typ;
  logic [DBI_IF_D_W-1:0] w_dat;
  logic                  w_no_dat;
  logic                  w_last;
  logic                  w_vld;
  logic                  w_pxl_rdy;
  logic [15:0]           w_end;
  logic [DBI_IF_D_W-1:0] w_coord_byte;
  logic                  w_pix_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_ST;
      tmr_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      buf_vld_q   <= 1'b0;
      sel_lo_q    <= 1'b0;
      init_done_q <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      sel_lo_q    <= sel_lo_d;
      init_done_q <= init_done_d;
      arm_q       <= arm_d;
    end
  end

  // Column/row end coordinate for the address-window commands, sent MSB first
  // after two zero bytes of start coordinate.
  always_comb begin
    w_end        = (state_q == CASET_ST) ? C_COL_END : C_ROW_END;
    w_coord_byte = '0;
    case (idx_q)
      2'd2:    w_coord_byte = DBI_IF_D_W'(w_end[15:8]);
      2'd3:    w_coord_byte = DBI_IF_D_W'(w_end[7:0]);
      default: w_coord_byte = '0;
    endcase
  end

  assign w_pix_last = (cnt_q == C_PIX_LAST) && sel_lo_q;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    sel_lo_d    = sel_lo_q;
    init_done_d = init_done_q;
    arm_d       = 1'b1;

    w_hrst      = 1'b0;
    w_typ       = '0;
    w_dat       = '0;
    w_no_dat    = 1'b0;
    w_last      = 1'b0;
    w_vld       = 1'b0;
    w_pxl_rdy   = 1'b0;

    case (state_q)
      RST_ST: begin
        w_vld  = arm_q;
        w_hrst = arm_q;
        if (arm_q && bus.dtf_tx_rdy_i) begin
          state_d = HW_WAIT;
          tmr_d   = C_HRST_LOAD;
        end
      end

      HW_WAIT: begin
        if (tmr_q == '0) state_d = SLPOUT_ST;
        else             tmr_d   = tmr_q - C_TMR_W'(1);
      end

      SLPOUT_ST: begin
        w_vld    = 1'b1;
        w_typ    = C_CMD_SLPOUT;
        w_no_dat = 1'b1;
        if (bus.dtf_tx_rdy_i) begin
          state_d = SLP_WAIT;
          tmr_d   = C_SLP_LOAD;
        end
      end

      SLP_WAIT: begin
        if (tmr_q == '0) state_d = COLMOD_ST;
        else             tmr_d   = tmr_q - C_TMR_W'(1);
      end

      COLMOD_ST: begin
        w_vld  = 1'b1;
        w_typ  = C_CMD_COLMOD;
        w_dat  = C_DAT_COLMOD;
        w_last = 1'b1;
        if (bus.dtf_tx_rdy_i) state_d = DISPON_ST;
      end

      DISPON_ST: begin
        w_vld    = 1'b1;
        w_typ    = C_CMD_DISPON;
        w_no_dat = 1'b1;
        if (bus.dtf_tx_rdy_i) begin
          state_d     = CASET_ST;
          idx_d       = 2'd0;
          init_done_d = 1'b1;
        end
      end

      CASET_ST, RASET_ST: begin
        w_vld  = 1'b1;
        // Command byte rides only on the first beat of the transaction.
        if (idx_q == 2'd0)
          w_typ = (state_q == CASET_ST) ? C_CMD_CASET : C_CMD_RASET;
        w_dat  = w_coord_byte;
        w_last = (idx_q == 2'd3);
        if (bus.dtf_tx_rdy_i) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3)
            state_d = (state_q == CASET_ST) ? RASET_ST : RAMWR_ST;
        end
      end

      RAMWR_ST: begin
        // Ready comes from the registered buffer flag, so a buffer freed this
        // cycle is refilled on the next one at the earliest.
        w_pxl_rdy = ~buf_vld_q;
        if (bus.pxl_vld_i && !buf_vld_q) begin
          buf_d     = bus.pxl_dat_i;
          buf_vld_d = 1'b1;
        end

        w_vld = buf_vld_q;
        if (buf_vld_q) begin
          w_dat  = sel_lo_q ? buf_q[DBI_IF_D_W-1:0]
                            : buf_q[PXL_W-1 -: DBI_IF_D_W];
          if ((cnt_q == '0) && !sel_lo_q) w_typ = C_CMD_RAMWR;
          w_last = w_pix_last;
          if (bus.dtf_tx_rdy_i) begin
            if (!sel_lo_q) begin
              sel_lo_d = 1'b1;
            end else begin
              sel_lo_d  = 1'b0;
              buf_vld_d = 1'b0;
              if (w_pix_last) begin
                cnt_d   = '0;
                idx_d   = 2'd0;
                state_d = CASET_ST;
              end else begin
                cnt_d = cnt_q + C_CNT_W'(1);
              end
            end
          end
        end
      end

      default: state_d = RST_ST;
    endcase
  end

  assign bus.dtf_dbi_hrst_o   = w_hrst;
  assign bus.dtf_tx_cmd_typ_o = w_typ;
  assign bus.dtf_tx_cmd_dat_o = w_dat;
  assign bus.dtf_tx_no_dat_o  = w_no_dat;
  assign bus.dtf_tx_last_o    = w_last;
  assign bus.dtf_tx_vld_o     = w_vld;
  assign bus.pxl_rdy_o        = w_pxl_rdy;
  assign init_done_o          = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dbi_tx_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dbi_tx_fsm
// Purpose  : Directed self-checking bench for dbi_tx_fsm with a 4x2 frame and
//            1 us bring-up waits (125 cycles at 125 MHz).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbi_tx_fsm;

  localparam int H = 4;
  localparam int V = 2;
  localparam int NB = 24; // 4 CASET + 4 RASET + 16 RAMWR beats per frame

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;
  always #5 clk = ~clk;

  dbi_tx_fsm_if #(.DBI_IF_D_W(8), .PXL_W(16)) bus ();

  dbi_tx_fsm #(
    .INTERNAL_CLK     (125000000),
    .DBI_IF_D_W       (8),
    .PXL_W            (16),
    .H_RES            (H),
    .V_RES            (V),
    .T_HRST_WAIT_SEC  (1e-6),
    .T_SLPOUT_WAIT_SEC(1e-6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .init_done_o(init_done)
  );

  int total = 0;
  int bad   = 0;

  bit src_en    = 1'b0;
  int src_epoch = 0;
  int src_idx;
  int rdy_mode  = 0; // 0: always ready, 1: random, 2: held low

  logic [18:0] exp_fr [NB];
  logic [18:0] got    [NB];
  int          frame_unstable;
  bit          frame_ok;

  function automatic logic [18:0] mk(logic h, logic [7:0] t, logic [7:0] d,
                                     logic n, logic l);
    return {h, t, d, n, l};
  endfunction

  function automatic logic [18:0] cur_beat();
    return {bus.dtf_dbi_hrst_o, bus.dtf_tx_cmd_typ_o, bus.dtf_tx_cmd_dat_o,
            bus.dtf_tx_no_dat_o, bus.dtf_tx_last_o};
  endfunction

  // Pixel source: pixel k of a frame is 0xA1B2 + k; an epoch bump restarts k.
  initial begin : pixel_source
    int last_ep;
    bit take;
    last_ep = 0;
    src_idx = 0;
    bus.pxl_vld_i = 1'b0;
    bus.pxl_dat_i = '0;
    forever begin
      @(negedge clk);
      take = bus.pxl_vld_i && bus.pxl_rdy_o;
      @(posedge clk);
      #1;
      if (src_epoch != last_ep) begin
        last_ep = src_epoch;
        src_idx = 0;
      end else if (take) begin
        src_idx++;
      end
      bus.pxl_dat_i = 16'hA1B2 + 16'(src_idx);
      bus.pxl_vld_i = src_en;
    end
  end

  // PHY ready driver
  initial begin : phy_ready
    bus.dtf_tx_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.dtf_tx_rdy_i = 1'($urandom_range(0, 1));
        2:       bus.dtf_tx_rdy_i = 1'b0;
        default: bus.dtf_tx_rdy_i = 1'b1;
      endcase
    end
  end

  // Waits for the next handshake; also counts beats whose fields moved or
  // whose valid dropped while waiting for ready.
  task automatic get_beat(input int budget, output logic [18:0] beat,
                          output int waited, output int unstable, output bit ok);
    logic [18:0] prev;
    logic [18:0] cur;
    bit hold;
    hold = 1'b0; prev = '0; ok = 1'b0; unstable = 0; waited = 0; beat = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      waited++;
      cur = cur_beat();
      if (hold && (!bus.dtf_tx_vld_o || cur !== prev)) unstable++;
      if (bus.dtf_tx_vld_o && bus.dtf_tx_rdy_i) begin
        beat = cur;
        ok   = 1'b1;
      end
      hold = bus.dtf_tx_vld_o;
      prev = cur;
    end
  endtask

  task automatic get_frame();
    int w, u;
    bit ok;
    frame_unstable = 0;
    frame_ok = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (frame_ok) begin
        get_beat(200, got[i], w, u, ok);
        frame_unstable += u;
        if (!ok) frame_ok = 1'b0;
      end
    end
  endtask

  task automatic wait_src(input int n);
    for (int i = 0; i < 500 && src_idx < n; i++) @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; src_en = 1'b0; rdy_mode = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({cur_beat(), bus.dtf_tx_vld_o, bus.pxl_rdy_o, init_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {cur_beat(), bus.dtf_tx_vld_o, bus.pxl_rdy_o, init_done});
    end
    rst_n = 1'b1;
    #1;
    total++;
    if ({bus.dtf_tx_vld_o, init_done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_release: vld/init_done got %b required 00",
               {bus.dtf_tx_vld_o, init_done});
    end
  endtask

  task automatic test_bringup();
    logic [18:0] b;
    int w, u;
    bit ok;
    get_beat(10, b, w, u, ok);
    total++;
    if (!ok || b !== mk(1, 8'h00, 8'h00, 0, 0)) begin
      bad++; $display("FAIL hrst_beat: got %h ok=%0d required %h", b, ok, mk(1, 0, 0, 0, 0));
    end
    get_beat(400, b, w, u, ok);
    total++;
    if (!ok || b !== mk(0, 8'h11, 8'h00, 1, 0)) begin
      bad++; $display("FAIL slpout_beat: got %h ok=%0d required %h", b, ok, mk(0, 8'h11, 0, 1, 0));
    end
    total++;
    if (w - 1 < 125) begin
      bad++; $display("FAIL hrst_wait: got %0d idle cycles required >=125", w - 1);
    end
    get_beat(400, b, w, u, ok);
    total++;
    if (!ok || b !== mk(0, 8'h3A, 8'h55, 0, 1)) begin
      bad++; $display("FAIL colmod_beat: got %h ok=%0d required %h", b, ok, mk(0, 8'h3A, 8'h55, 0, 1));
    end
    total++;
    if (w - 1 < 125) begin
      bad++; $display("FAIL slpout_wait: got %0d idle cycles required >=125", w - 1);
    end
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL init_done_early: got %b required 0", init_done);
    end
    get_beat(20, b, w, u, ok);
    total++;
    if (!ok || b !== mk(0, 8'h29, 8'h00, 1, 0)) begin
      bad++; $display("FAIL dispon_beat: got %h ok=%0d required %h", b, ok, mk(0, 8'h29, 0, 1, 0));
    end
    @(posedge clk);
    #1;
    total++;
    if (init_done !== 1'b1) begin
      bad++; $display("FAIL init_done_set: got %b required 1", init_done);
    end
  endtask

  task automatic test_frame();
    src_epoch++; src_en = 1'b1; rdy_mode = 0;
    get_frame();
    total++;
    if (!frame_ok) begin bad++; $display("FAIL frame_timeout: got 0 required 1"); end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (got[i] !== exp_fr[i]) begin
        bad++; $display("FAIL frame beat %0d: got %h required %h", i, got[i], exp_fr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    src_epoch++; src_en = 1'b1; rdy_mode = 1;
    get_frame();
    rdy_mode = 0;
    total++;
    if (!frame_ok) begin bad++; $display("FAIL bp_timeout: got 0 required 1"); end
    total++;
    if (frame_unstable != 0) begin
      bad++; $display("FAIL bp_stable: got %0d unstable cycles required 0", frame_unstable);
    end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (got[i] !== exp_fr[i]) begin
        bad++; $display("FAIL bp beat %0d: got %h required %h", i, got[i], exp_fr[i]);
      end
    end
  endtask

  task automatic test_starve();
    src_epoch++; src_en = 1'b1; rdy_mode = 0;
    fork
      get_frame();
      begin
        wait_src(1);
        src_en = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if ({bus.dtf_tx_vld_o, bus.pxl_rdy_o} !== 2'b01) begin
          bad++; $display("FAIL starve_mid vld/rdy: got %b required 01", {bus.dtf_tx_vld_o, bus.pxl_rdy_o});
        end
        src_en = 1'b1;
        wait_src(4);
        src_en = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if ({bus.dtf_tx_vld_o, bus.pxl_rdy_o} !== 2'b01) begin
          bad++; $display("FAIL starve_gap vld/rdy: got %b required 01", {bus.dtf_tx_vld_o, bus.pxl_rdy_o});
        end
        src_en = 1'b1;
        wait_src(6);
        rdy_mode = 2;
        repeat (6) @(negedge clk);
        total++;
        if ({bus.dtf_tx_vld_o, bus.pxl_rdy_o} !== 2'b10) begin
          bad++; $display("FAIL full_buf vld/rdy: got %b required 10", {bus.dtf_tx_vld_o, bus.pxl_rdy_o});
        end
        rdy_mode = 0;
      end
    join
    total++;
    if (!frame_ok) begin bad++; $display("FAIL starve_timeout: got 0 required 1"); end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (got[i] !== exp_fr[i]) begin
        bad++; $display("FAIL starve beat %0d: got %h required %h", i, got[i], exp_fr[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    rdy_mode = 0; src_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      src_epoch++;
      get_frame();
      total++;
      if (!frame_ok) begin bad++; $display("FAIL b2b_timeout frame %0d: got 0 required 1", f); end
      for (int i = 0; i < NB; i++) begin
        total++;
        if (got[i] !== exp_fr[i]) begin
          bad++; $display("FAIL b2b frame %0d beat %0d: got %h required %h", f, i, got[i], exp_fr[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] b;
    int w, u;
    bit ok;
    src_epoch++; src_en = 1'b1; rdy_mode = 0;
    for (int i = 0; i < 14; i++) get_beat(200, b, w, u, ok);
    total++;
    if (!ok || b !== exp_fr[13]) begin
      bad++; $display("FAIL mid_beat6: got %h ok=%0d required %h", b, ok, exp_fr[13]);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cur_beat(), bus.dtf_tx_vld_o, bus.pxl_rdy_o, init_done} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %h required 0",
               {cur_beat(), bus.dtf_tx_vld_o, bus.pxl_rdy_o, init_done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    get_beat(10, b, w, u, ok);
    total++;
    if (!ok || b !== mk(1, 8'h00, 8'h00, 0, 0)) begin
      bad++; $display("FAIL mid_hrst_beat: got %h ok=%0d required %h", b, ok, mk(1, 0, 0, 0, 0));
    end
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL mid_init_done: got %b required 0", init_done);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin : main
    // Expected frame: CASET 0,0,0,3 / RASET 0,0,0,1 / RAMWR A1,B2,A1,B3,...
    exp_fr[0] = mk(0, 8'h2A, 8'h00, 0, 0);
    exp_fr[1] = mk(0, 8'h00, 8'h00, 0, 0);
    exp_fr[2] = mk(0, 8'h00, 8'h00, 0, 0);
    exp_fr[3] = mk(0, 8'h00, 8'h03, 0, 1);
    exp_fr[4] = mk(0, 8'h2B, 8'h00, 0, 0);
    exp_fr[5] = mk(0, 8'h00, 8'h00, 0, 0);
    exp_fr[6] = mk(0, 8'h00, 8'h00, 0, 0);
    exp_fr[7] = mk(0, 8'h00, 8'h01, 0, 1);
    for (int k = 0; k < 16; k++) begin
      exp_fr[8 + k] = mk(0, (k == 0) ? 8'h2C : 8'h00,
                         (k % 2 == 1) ? 8'(8'hB2 + k / 2) : 8'hA1,
                         0, (k == 15));
    end

    test_reset();
    test_bringup();
    test_frame();
    test_backpressure();
    test_starve();
    test_back_to_back();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #300us;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/dbi_tx_fsm.md
Name: dbi_tx_fsm

Overview:
- Sequencer directly upstream of the DBI TX PHY. It generates the panel bring-up sequence: hardware reset, SLPOUT, COLMOD, DISPON.
- It then loops per frame: CASET, RASET, then RAMWR streaming RGB565 pixels from the pixel source.
- It drives the PHY beat interface (hrst/cmd_typ/cmd_dat/no_dat/last/vld, rdy) and backpressures the pixel stream.

Parameters:
- INTERNAL_CLK, 125000000, clock frequency in Hz, used for wait timers.
- DBI_IF_D_W, 8, DBI byte width.
- PXL_W, 16, pixel width (RGB565, 2 bytes per pixel).
- H_RES, 320, columns per frame.
- V_RES, 240, rows per frame.
- T_HRST_WAIT_SEC, 120e-3, wait after HW-reset beat accepted.
- T_SLPOUT_WAIT_SEC, 120e-3, wait after SLPOUT beat accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pxl_dat_i  in  PXL_W  pixel data, bits [15:8] sent first.
- pxl_vld_i  in  1  pixel valid.
- pxl_rdy_o  out  1  pixel accepted when pxl_vld_i & pxl_rdy_o.
- dtf_tx_rdy_i  in  1  PHY ready.
- dtf_dbi_hrst_o  out  1  beat is a hardware-reset request.
- dtf_tx_cmd_typ_o  out  DBI_IF_D_W  command byte (first beat of a transaction).
- dtf_tx_cmd_dat_o  out  DBI_IF_D_W  parameter/data byte.
- dtf_tx_no_dat_o  out  1  command carries no parameters.
- dtf_tx_last_o  out  1  this data byte is the last of the transaction.
- dtf_tx_vld_o  out  1  beat valid.
- init_done_o  out  1  bring-up finished; frame loop running.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0. State RST_ST; timer, pixel counter, byte index and pixel buffer all cleared.
- Beat rule:
  - A beat is transferred on dtf_tx_vld_o & dtf_tx_rdy_i.
  - Once vld is high, vld and all fields hold stable until the handshake; vld never drops without a handshake.
  - The first beat of a transaction carries cmd_typ, the first data byte, no_dat and last. Following beats carry only cmd_dat and last.
  - Fields are don't-care where unused; drive 0.
- Timer: derived cycle counts use $rtoi(SEC*INTERNAL_CLK). Timer width is $clog2 of the larger count. The timer loads count-1 and decrements to 0.
- Bring-up states and transitions:
  - RST_ST: beat with hrst=1.
  - Handshake -> HW_WAIT: wait T_HRST_WAIT.
  - SLPOUT_ST: cmd 0x11, no_dat=1; handshake -> SLP_WAIT (T_SLPOUT_WAIT).
  - COLMOD_ST: cmd 0x3A, dat 0x55, last=1.
  - DISPON_ST: cmd 0x29, no_dat=1; handshake -> CASET_ST, init_done_o<=1 (sticky until reset).
- Frame loop:
  - CASET_ST: cmd 0x2A, 4 bytes {0x00, 0x00, (H_RES-1)[15:8], (H_RES-1)[7:0]}; last on byte index 3. A 2-bit byte index advances per handshake.
  - RASET_ST: cmd 0x2B, same layout with V_RES-1.
  - RAMWR_ST: cmd 0x2C, 2*H_RES*V_RES data bytes. The first beat carries cmd 0x2C plus the high byte of pixel 0.
- Pixel path:
  - One-entry pixel buffer plus a hi/lo byte select.
  - pxl_rdy_o = (state==RAMWR_ST) & ~buf_vld.
  - dtf_tx_vld_o = buf_vld in RAMWR_ST.
  - High-byte handshake -> select lo. Low-byte handshake -> buf_vld clear, select hi, pixel counter +1.
  - No pixel is accepted in the same cycle the buffer frees; one bubble cycle is allowed.
- Last byte of a frame: last=1 when pixel counter == H_RES*V_RES-1 and select=lo. On that handshake, counter <= 0 and the FSM goes to CASET_ST (next frame).
- Pixel counter width: $clog2(H_RES*V_RES). It wraps only via the frame-end rule.
- Stalls:
  - Pixel source starvation leaves vld low; the byte stream resumes unchanged.
  - PHY backpressure holds the current beat.
- Reset mid-operation (rst_n low at any time): immediate return to RST_ST. init_done_o=0, buffer dropped. Bring-up restarts with the hrst beat.
- No command is issued while a timer is running.

Test Plan:
- Bring-up with timers overridden to 1e-6 s and PHY always ready. Expected beat sequence:
  - hrst; wait ≥125 cycles; 0x11 (no_dat).
  - wait ≥125 cycles; 0x3A/0x55 last.
  - 0x29 (no_dat); then init_done_o=1.
- H_RES=4, V_RES=2, pixels 0xA1B2.. incrementing. Expected:
  - CASET bytes 00,00,00,03; RASET bytes 00,00,00,01.
  - RAMWR 16 bytes A1,B2,A1,B3,…; last only on byte 16.
- Random dtf_tx_rdy_i backpressure (~50%) -> fields stable while vld high without rdy; byte stream identical to the previous test.
- pxl_vld_i low for 20 cycles mid-pixel and between pixels -> no spurious beats, no duplicated or dropped bytes; pxl_rdy_o low while the buffer is full.
- Two back-to-back frames -> second frame starts with CASET/RASET/RAMWR again; pixel count restarts at 0.
- rst_n asserted mid-RAMWR at byte 7 -> all outputs 0 asynchronously; after release the first beat is hrst=1 and init_done_o=0.
